// File: rtl/serial_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_pkg : register map, bit indices and FSM encoding for as2650_serial_port
// Rev 1.0
// ---------------------------------------------------------------------------
package serial_pkg;

   localparam logic [5:0] c_ADDR_DATA   = 6'h00;
   localparam logic [5:0] c_ADDR_STATUS = 6'h01;
   localparam logic [5:0] c_ADDR_CTRL   = 6'h02;
   localparam logic [5:0] c_ADDR_DIV_LO = 6'h03;
   localparam logic [5:0] c_ADDR_DIV_HI = 6'h04;

   localparam int c_STAT_RX_VALID  = 0;
   localparam int c_STAT_TX_BUSY   = 1;
   localparam int c_STAT_TX_FULL   = 2;
   localparam int c_STAT_OVERRUN   = 3;
   localparam int c_STAT_FRAME_ERR = 4;

   localparam int c_CTRL_TX_EN     = 0;
   localparam int c_CTRL_RX_EN     = 1;
   localparam int c_CTRL_RX_IRQ_EN = 2;
   localparam int c_CTRL_TX_IRQ_EN = 3;

   localparam logic [15:0] c_DEFAULT_DIV = 16'h0067;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } serial_state_t;

endpackage
`default_nettype wire

// File: rtl/as2650_serial_port_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// as2650_serial_port_if : AS2650 internal IO-bus signals for the serial slot
// Rev 1.0
// ---------------------------------------------------------------------------
interface as2650_serial_port_if;
   logic       bus_cyc;
   logic       bus_we;
   logic [5:0] bus_addr;
   logic [7:0] bus_wdata;
   logic [7:0] bus_rdata;

   modport master (output bus_cyc, bus_we, bus_addr, bus_wdata, input bus_rdata);
   modport slave  (input bus_cyc, bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface
`default_nettype wire

// File: rtl/serial_port_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_port_rx : rxd synchronizer, 8N1 receive FSM and RX buffer
//                  (4-entry FIFO when SERIAL_RX_FIFO_EN is defined)  Rev 1.0
// ---------------------------------------------------------------------------
module serial_port_rx
   import serial_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        i_rxd,
   input  wire logic        i_en,
   input  wire logic [15:0] i_div,
   input  wire logic        i_pop,
   input  wire logic        i_clr_err,
   output logic [7:0]       o_data,
   output logic             o_valid,
   output logic             o_overrun,
   output logic             o_frame_err
);
   logic [1:0]    r_sync;
   logic          r_rx_prev;
   serial_state_t r_state;
   logic [15:0]   r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_overrun;
   logic          r_frame_err;

   logic          w_rx;
   logic          w_fall;
   logic          w_tick;
   logic [16:0]   w_half;
   logic [15:0]   w_half_load;
   logic          w_stop_pt;
   logic          w_done;
   logic          w_push;

   assign w_rx        = r_sync[1];
   assign w_fall      = r_rx_prev & ~w_rx;
   assign w_tick      = (r_cnt == 16'd0);
   assign w_half      = ({1'b0, i_div} + 17'd1) >> 1;
   assign w_half_load = (w_half == 17'd0) ? 16'd0 : (w_half[15:0] - 16'd1);
   assign w_stop_pt   = i_en && (r_state == S_STOP) && w_tick;
   assign w_done      = w_stop_pt & w_rx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync    <= 2'b11;
         r_rx_prev <= 1'b1;
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_bit     <= 3'd0;
         r_shift   <= 8'h00;
      end else begin
         r_sync    <= {r_sync[0], i_rxd};
         r_rx_prev <= w_rx;
         if (!i_en) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_fall) begin
                     r_state <= S_START;
                     r_cnt   <= w_half_load;
                  end
               end
               S_START: begin
                  // Mid-start check: a line already back high was a glitch.
                  if (w_tick) begin
                     if (w_rx) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_state <= S_DATA;
                        r_cnt   <= i_div;
                        r_bit   <= 3'd0;
                     end
                  end else begin
                     r_cnt <= r_cnt - 16'd1;
                  end
               end
               S_DATA: begin
                  if (w_tick) begin
                     r_shift <= {w_rx, r_shift[7:1]};
                     r_bit   <= r_bit + 3'd1;
                     r_cnt   <= i_div;
                     if (r_bit == 3'd7) r_state <= S_STOP;
                  end else begin
                     r_cnt <= r_cnt - 16'd1;
                  end
               end
               S_STOP: begin
                  if (w_tick) r_state <= S_IDLE;
                  else        r_cnt   <= r_cnt - 16'd1;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_frame_err <= 1'b0;
      else if (w_stop_pt && !w_rx)  r_frame_err <= 1'b1;
      else if (i_clr_err)           r_frame_err <= 1'b0;
   end

`ifdef SERIAL_RX_FIFO_EN
   logic [7:0] r_mem [0:3];
   logic [1:0] r_wp;
   logic [1:0] r_rp;
   logic [2:0] r_count;
   logic       w_pop;

   assign w_pop  = i_pop && (r_count != 3'd0);
   assign w_push = w_done && ((r_count != 3'd4) || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= r_shift;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp      <= 2'd0;
         r_rp      <= 2'd0;
         r_count   <= 3'd0;
         r_overrun <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + 2'd1;
         if (w_pop)  r_rp <= r_rp + 2'd1;
         r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
         if (w_done && !w_push) r_overrun <= 1'b1;
         else if (i_clr_err)    r_overrun <= 1'b0;
      end
   end

   assign o_data  = r_mem[r_rp];
   assign o_valid = (r_count != 3'd0);
`else
   logic [7:0] r_data;
   logic       r_valid;

   assign w_push = w_done && (!r_valid || i_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data    <= 8'h00;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_push) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (i_pop) begin
            r_valid <= 1'b0;
         end
         if (w_done && !w_push) r_overrun <= 1'b1;
         else if (i_clr_err)    r_overrun <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
`endif

   assign o_overrun   = r_overrun;
   assign o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/as2650_serial_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// as2650_serial_port : 8N1 UART responder on the AS2650 IO bus (slot 2);
//                      SERIAL_RX_FIFO_EN selects a 4-entry RX FIFO   Rev 1.0
// ---------------------------------------------------------------------------
module as2650_serial_port
   import serial_pkg::*;
#(
   parameter logic [15:0] RESET_DIV = c_DEFAULT_DIV
) (
   input  wire logic           wb_clk_i,
   input  wire logic           wb_rst_i,
   as2650_serial_port_if.slave bus,
   input  wire logic           rxd,
   output logic                txd,
   output logic                irq
);
   logic          r_cyc_d;
   logic [3:0]    r_ctrl;
   logic [15:0]   r_div;
   logic [7:0]    r_tx_hold;
   logic          r_tx_full;
   serial_state_t r_tx_state;
   logic [7:0]    r_tx_shift;
   logic [2:0]    r_tx_bit;
   logic [15:0]   r_tx_cnt;
   logic          r_txd;

   logic          w_start, w_wr, w_rd;
   logic          w_data_wr, w_accept, w_tx_load, w_tx_busy, w_tx_tick;
   logic [7:0]    w_rx_data, w_rdata;
   logic          w_rx_valid, w_overrun, w_frame_err;

   assign w_start   = bus.bus_cyc & ~r_cyc_d;
   assign w_wr      = w_start & bus.bus_we;
   assign w_rd      = w_start & ~bus.bus_we;
   assign w_data_wr = w_wr && (bus.bus_addr == c_ADDR_DATA);
   assign w_tx_load = (r_tx_state == S_IDLE) && r_ctrl[c_CTRL_TX_EN] && r_tx_full;
   // The holding register frees up in the load cycle, so a write then is taken.
   assign w_accept  = w_data_wr && (!r_tx_full || w_tx_load);
   assign w_tx_busy = (r_tx_state != S_IDLE);
   assign w_tx_tick = (r_tx_cnt == 16'd0);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_cyc_d <= 1'b0;
         r_ctrl  <= 4'h0;
         r_div   <= RESET_DIV;
      end else begin
         r_cyc_d <= bus.bus_cyc;
         if (w_wr) begin
            case (bus.bus_addr)
               c_ADDR_CTRL:   r_ctrl       <= bus.bus_wdata[3:0];
               c_ADDR_DIV_LO: r_div[7:0]   <= bus.bus_wdata;
               c_ADDR_DIV_HI: r_div[15:8]  <= bus.bus_wdata;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_tx_hold <= 8'h00;
         r_tx_full <= 1'b0;
      end else if (w_accept) begin
         r_tx_hold <= bus.bus_wdata;
         r_tx_full <= 1'b1;
      end else if (w_tx_load) begin
         r_tx_full <= 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_tx_state <= S_IDLE;
         r_tx_shift <= 8'h00;
         r_tx_bit   <= 3'd0;
         r_tx_cnt   <= 16'd0;
         r_txd      <= 1'b1;
      end else begin
         case (r_tx_state)
            S_IDLE: begin
               if (w_tx_load) begin
                  r_tx_state <= S_START;
                  r_tx_shift <= r_tx_hold;
                  r_tx_cnt   <= r_div;
                  r_txd      <= 1'b0;
               end
            end
            S_START: begin
               if (w_tx_tick) begin
                  r_tx_state <= S_DATA;
                  r_txd      <= r_tx_shift[0];
                  r_tx_shift <= r_tx_shift >> 1;
                  r_tx_bit   <= 3'd0;
                  r_tx_cnt   <= r_div;
               end else begin
                  r_tx_cnt <= r_tx_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (w_tx_tick) begin
                  r_tx_cnt <= r_div;
                  if (r_tx_bit == 3'd7) begin
                     r_tx_state <= S_STOP;
                     r_txd      <= 1'b1;
                  end else begin
                     r_txd      <= r_tx_shift[0];
                     r_tx_shift <= r_tx_shift >> 1;
                     r_tx_bit   <= r_tx_bit + 3'd1;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (w_tx_tick) r_tx_state <= S_IDLE;
               else           r_tx_cnt   <= r_tx_cnt - 16'd1;
            end
            default: r_tx_state <= S_IDLE;
         endcase
      end
   end

   serial_port_rx u_rx (
      .clk         (wb_clk_i),
      .rst         (wb_rst_i),
      .i_rxd       (rxd),
      .i_en        (r_ctrl[c_CTRL_RX_EN]),
      .i_div       (r_div),
      .i_pop       (w_rd && (bus.bus_addr == c_ADDR_DATA)),
      .i_clr_err   (w_rd && (bus.bus_addr == c_ADDR_STATUS)),
      .o_data      (w_rx_data),
      .o_valid     (w_rx_valid),
      .o_overrun   (w_overrun),
      .o_frame_err (w_frame_err)
   );

   always_comb begin
      w_rdata = 8'h00;
      case (bus.bus_addr)
         c_ADDR_DATA:   w_rdata = w_rx_data;
         c_ADDR_STATUS: w_rdata = {3'b000, w_frame_err, w_overrun, r_tx_full, w_tx_busy, w_rx_valid};
         c_ADDR_CTRL:   w_rdata = {4'h0, r_ctrl};
         c_ADDR_DIV_LO: w_rdata = r_div[7:0];
         c_ADDR_DIV_HI: w_rdata = r_div[15:8];
         default:       w_rdata = 8'h00;
      endcase
   end

   assign bus.bus_rdata = w_rdata;
   assign txd = r_txd;
   assign irq = (r_ctrl[c_CTRL_RX_IRQ_EN] & w_rx_valid) | (r_ctrl[c_CTRL_TX_IRQ_EN] & ~r_tx_full);

endmodule
`default_nettype wire

// File: tb/tb_as2650_serial_port.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_as2650_serial_port : directed stimulus with queued expectations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_as2650_serial_port;
   import serial_pkg::*;

   typedef struct { string name; logic [7:0] exp; } rd_exp_t;
   typedef struct { string name; int sel; logic exp; } pr_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;
   logic txd;
   logic irq;

   as2650_serial_port_if bus_if();

   as2650_serial_port #(.RESET_DIV(16'h0067)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus_if),
      .rxd      (rxd),
      .txd      (txd),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   rd_exp_t    rd_q[$];
   pr_exp_t    pr_q[$];
   logic [7:0] tx_q[$];
   int         checks    = 0;
   int         failures  = 0;
   int         bit_clks  = 4;
   logic       probe_req = 1'b0;
   logic       cyc_prev  = 1'b0;
   logic       tx_prev   = 1'b1;

   task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      bus_if.bus_cyc = 1'b1; bus_if.bus_we = 1'b1;
      bus_if.bus_addr = a;   bus_if.bus_wdata = d;
      @(posedge clk); #1;
      bus_if.bus_cyc = 1'b0; bus_if.bus_we = 1'b0;
   endtask

   task automatic bus_read(input string n, input logic [5:0] a, input logic [7:0] e);
      rd_q.push_back('{n, e});
      @(posedge clk); #1;
      bus_if.bus_cyc = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = a;
      @(posedge clk); #1;
      bus_if.bus_cyc = 1'b0;
   endtask

   // Samples the selected output (0 = txd, 1 = irq) in the current cycle.
   task automatic probe(input string n, input int sel, input logic e);
      pr_q.push_back('{n, sel, e});
      probe_req = 1'b1;
      @(posedge clk); #1;
      probe_req = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stop);
      @(posedge clk); #1; rxd = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (bit_clks) @(posedge clk); #1; rxd = d[i];
      end
      repeat (bit_clks) @(posedge clk); #1; rxd = stop;
      repeat (bit_clks) @(posedge clk); #1; rxd = 1'b1;
   endtask

   always @(negedge clk) begin : mon_rd
      rd_exp_t e;
      if (bus_if.bus_cyc && !cyc_prev && !bus_if.bus_we) begin
         checks++;
         if (rd_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected: addr=%02h got=%02h", bus_if.bus_addr, bus_if.bus_rdata);
         end else begin
            e = rd_q.pop_front();
            if (bus_if.bus_rdata !== e.exp) begin
               failures++;
               $display("FAIL %s: got=%02h expected=%02h", e.name, bus_if.bus_rdata, e.exp);
            end
         end
      end
      cyc_prev = bus_if.bus_cyc;
   end

   always @(negedge clk) begin : mon_probe
      pr_exp_t p;
      logic    v;
      if (probe_req && pr_q.size() != 0) begin
         p = pr_q.pop_front();
         v = (p.sel == 0) ? txd : irq;
         checks++;
         if (v !== p.exp) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b", p.name, v, p.exp);
         end
      end
   end

   always begin : mon_tx
      logic [7:0] b;
      logic [7:0] e;
      logic       ok;
      @(negedge clk);
      if (!rst && tx_prev && !txd) begin
         ok = 1'b1;
         b  = 8'h00;
         repeat (bit_clks / 2) @(negedge clk);
         if (txd !== 1'b0) ok = 1'b0;
         for (int i = 0; i < 8; i++) begin
            repeat (bit_clks) @(negedge clk);
            b[i] = txd;
         end
         repeat (bit_clks) @(negedge clk);
         if (txd !== 1'b1) ok = 1'b0;
         checks++;
         if (tx_q.size() == 0) begin
            failures++;
            $display("FAIL tx_unexpected: got byte=%02h framing_ok=%b", b, ok);
         end else begin
            e = tx_q.pop_front();
            if (!ok || b !== e) begin
               failures++;
               $display("FAIL tx_frame: got byte=%02h framing_ok=%b expected byte=%02h framing_ok=1", b, ok, e);
            end
         end
      end
      tx_prev = txd;
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_if.bus_cyc = 1'b0; bus_if.bus_we = 1'b0;
      bus_if.bus_addr = 6'h00; bus_if.bus_wdata = 8'h00;
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;

      // Reset state
      probe("rst_txd", 0, 1'b1);
      probe("rst_irq", 1, 1'b0);
      bus_read("rst_ctrl",   c_ADDR_CTRL,   8'h00);
      bus_read("rst_div_lo", c_ADDR_DIV_LO, 8'h67);
      bus_read("rst_div_hi", c_ADDR_DIV_HI, 8'h00);
      bus_read("rst_status", c_ADDR_STATUS, 8'h00);
      bus_read("unmapped",   6'h05,         8'h00);

      // TX of 0xA5 at DIV=3
      bus_write(c_ADDR_DIV_LO, 8'h03);
      bus_write(c_ADDR_DIV_HI, 8'h00);
      bus_write(6'h3F, 8'hFF);
      bus_read("div_lo_set", c_ADDR_DIV_LO, 8'h03);
      bus_write(c_ADDR_CTRL, 8'h01);
      tx_q.push_back(8'hA5);
      bus_write(c_ADDR_DATA, 8'hA5);
      probe("tx_n1_high", 0, 1'b1);
      probe("tx_n2_start", 0, 1'b0);
      repeat (37) @(posedge clk);
      bus_read("tx_busy_last", c_ADDR_STATUS, 8'h02);
      bus_read("tx_busy_clr",  c_ADDR_STATUS, 8'h00);

      // RX of 0x3C
      bus_write(c_ADDR_CTRL, 8'h02);
      send_rx(8'h3C, 1'b1);
      repeat (4) @(posedge clk);
      bus_read("rx_status", c_ADDR_STATUS, 8'h01);
      bus_read("rx_data",   c_ADDR_DATA,   8'h3C);
      bus_read("rx_popped", c_ADDR_STATUS, 8'h00);

      // Two frames without a read
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      repeat (4) @(posedge clk);
`ifdef SERIAL_RX_FIFO_EN
      bus_read("ovr_status1", c_ADDR_STATUS, 8'h01);
      bus_read("ovr_status2", c_ADDR_STATUS, 8'h01);
      bus_read("ovr_data1",   c_ADDR_DATA,   8'h11);
      bus_read("ovr_data2",   c_ADDR_DATA,   8'h22);
`else
      bus_read("ovr_status1", c_ADDR_STATUS, 8'h09);
      bus_read("ovr_status2", c_ADDR_STATUS, 8'h01);
      bus_read("ovr_data1",   c_ADDR_DATA,   8'h11);
`endif
      bus_read("ovr_empty", c_ADDR_STATUS, 8'h00);

      // Low stop bit, then a one-clock glitch
      send_rx(8'h55, 1'b0);
      repeat (4) @(posedge clk);
      bus_read("ferr_status", c_ADDR_STATUS, 8'h10);
      bus_read("ferr_clear",  c_ADDR_STATUS, 8'h00);
      @(posedge clk); #1; rxd = 1'b0;
      @(posedge clk); #1; rxd = 1'b1;
      repeat (60) @(posedge clk);
      bus_read("glitch_status", c_ADDR_STATUS, 8'h00);

      // Interrupts; 0x99 lands on a full holding register and is dropped
      bus_write(c_ADDR_CTRL, 8'h0C);
      probe("irq_tx_empty", 1, 1'b1);
      bus_write(c_ADDR_DATA, 8'h77);
      probe("irq_tx_full", 1, 1'b0);
      bus_write(c_ADDR_DATA, 8'h99);
      bus_read("tx_full_status", c_ADDR_STATUS, 8'h04);
      bus_write(c_ADDR_CTRL, 8'h0E);
      probe("irq_rx_empty", 1, 1'b0);
      send_rx(8'h81, 1'b1);
      repeat (4) @(posedge clk);
      probe("irq_rx_valid", 1, 1'b1);
      bus_read("irq_rx_data", c_ADDR_DATA, 8'h81);
      probe("irq_after_pop", 1, 1'b0);

      // Drain the held byte
      tx_q.push_back(8'h77);
      bus_write(c_ADDR_CTRL, 8'h01);
      repeat (100) @(posedge clk);

      checks++;
      if (rd_q.size() != 0 || pr_q.size() != 0 || tx_q.size() != 0) begin
         failures++;
         $display("FAIL queues_drained: got rd=%0d probe=%0d tx=%0d expected all 0",
                  rd_q.size(), pr_q.size(), tx_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/as2650_serial_port.md
# as2650_serial_port

Single-channel 8N1 UART that acts as a responder on the AS2650 internal IO bus, in the serial-ports slot (device_addr 2). The CPU side initiates reads and writes with bus_cyc, bus_we, bus_addr and write data. This block decodes those accesses, returns read data combinationally, and runs independent TX and RX engines clocked by the system clock. An interrupt request is raised for RX data available and for TX holding-register empty.

## Interface
Parameters:
- RESET_DIV, 16'h0067, reset value of the baud divider; bit period is DIV+1 clocks.

Ports:
- wb_clk_i  in  1  system clock; one clock only.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- bus_cyc  in  1  IO bus cycle active.
- bus_we  in  1  write strobe, qualified by bus_cyc and by this slot being selected.
- bus_addr  in  6  register address.
- bus_wdata  in  8  write data from the CPU.
- bus_rdata  out  8  read data; combinational from bus_addr.
- rxd  in  1  serial input; asynchronous; idles high.
- txd  out  1  serial output; idles high.
- irq  out  1  level interrupt request.

## Operation
- Access start: the cycle in which bus_cyc=1 and bus_cyc was 0 in the previous cycle. Side effects happen only at access start. Extra cycles of a held bus_cyc have no further effect.
- Register map, decoded on bus_addr[5:0]:
  - 0x00 DATA: write loads the TX holding register; read returns the RX byte and pops it.
  - 0x01 STATUS (read-only): [0] rx_valid, [1] tx_busy, [2] tx_full, [3] overrun, [4] frame_err, [7:5] 0. Reading STATUS clears overrun and frame_err.
  - 0x02 CTRL (RW): [0] tx_en, [1] rx_en, [2] rx_irq_en, [3] tx_irq_en. Bits [7:4] read 0.
  - 0x03 DIV_LO (RW), 0x04 DIV_HI (RW).
  - Any other address reads 0x00; writes to it are ignored.
- Write to DATA while tx_full=1: the byte is dropped and no flag is set.
- TX state machine, IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE.
  - In IDLE, if tx_en=1 and the holding register is full, the shifter loads from it and tx_full clears.
  - DATA write in the same cycle as that load: the write is accepted and tx_full stays 1.
  - Clearing tx_en mid-frame: the current frame completes, then no new load occurs.
- RX state machine, IDLE→START→DATA→STOP.
  - rxd passes through a 2-flop synchronizer.
  - A falling edge starts the frame. At half a bit period (DIV+1)>>1, rxd must still be low, otherwise return to IDLE (glitch rejected).
  - Bits are then sampled every DIV+1 clocks.
  - Stop bit low: frame_err is set and the byte is discarded.
  - Completed byte with the buffer full: overrun is set and the new byte is dropped.
  - Pop and completion in the same cycle with the buffer full: the new byte is stored and overrun is not set.
  - rx_en=0 forces RX to IDLE immediately; the buffer is kept.
- Divider writes take effect at the next bit-counter reload. The current bit finishes at the old rate.
- irq = (rx_irq_en & rx_valid) | (tx_irq_en & ~tx_full).
- Reset values:
  - txd=1, irq=0, bus_rdata reflects reset registers.
  - CTRL=0x00, DIV=RESET_DIV.
  - All flags 0, buffers empty, both FSMs in IDLE.
- Asserting reset mid-frame aborts immediately and txd returns to 1.

## Timing
- Write to DATA at access start in cycle N: tx_full=1 at N+1, shifter loads at N+1, txd falls at N+2.
- TX frame: 10 bit periods of DIV+1 clocks each.
- tx_busy is high from the load through the last clock of the stop bit.
- RX: rx_valid rises one clock after the stop-bit sample point.
- Synchronizer latency is 2 clocks.
- Read data is valid in the same cycle as the address. The pop takes effect at the next clock.

## Configuration
- SERIAL_RX_FIFO_EN defined: the RX buffer is a 4-entry FIFO.
  - rx_valid means the FIFO is not empty.
  - overrun is set only when a byte completes with 4 entries held.
- SERIAL_RX_FIFO_EN undefined: the RX buffer is a single byte with the rules above.

## Structure
- Package serial_pkg holds:
  - register address constants;
  - STATUS and CTRL bit indices;
  - the TX/RX state typedef (IDLE, START, DATA, STOP);
  - the default divider constant.
- One sub-module, serial_port_rx: synchronizer, RX state machine and the RX buffer/FIFO. TX and bus decode stay in the top module.

## Test plan
- Reset, then read all registers → CTRL=0x00, DIV_LO=0x67, DIV_HI=0x00, STATUS=0x00, txd=1, irq=0.
- DIV=3, CTRL=0x01, write DATA=0xA5 → txd start falls 2 cycles after access start. Bits 1,0,1,0,0,1,0,1 then stop follow at 4 clocks each; tx_busy clears after 40 clocks.
- DIV=3, CTRL=0x02, drive 0x3C frame on rxd → rx_valid=1. Read DATA returns 0x3C; rx_valid=0 on the next cycle.
- Two RX frames with no read, single-byte build → first byte kept and overrun=1. STATUS read returns 0x09, then 0x01.
- RX frame with low stop bit → frame_err=1, rx_valid=0. A 1-clock low glitch on rxd → no frame.
- CTRL=0x0C with tx_en=0 → irq=1. Write DATA → irq=0. Receive a byte with rx_irq_en set → irq=1.
